// File: rtl/rhd_convert_sequencer_pkg.sv
// ============================================================================
// Module  : rhd_convert_sequencer_pkg
// Brief   : Shared FSM states, CONVERT opcode and command-word builder for the
//           RHD2164 convert sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package rhd_convert_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT        = 3'd2,
        ST_FLUSH_ISSUE = 3'd3,
        ST_FLUSH_WAIT  = 3'd4
    } seq_state_t;

    localparam logic [1:0] c_CONVERT_OP = 2'b00;

    function automatic logic [15:0] build_convert_cmd(input logic [5:0] idx, input logic h);
        return {c_CONVERT_OP, idx, 7'b000_0000, h};
    endfunction

endpackage

`default_nettype wire

// File: rtl/rhd_convert_sequencer_tag.sv
// ============================================================================
// Module  : rhd_tag_pipe
// Brief   : Two-deep tag/valid delay line; each push returns the tag pushed two
//           pushes earlier, matching the RHD2164 two-command result latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rhd_tag_pipe #(
    parameter int TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_valid,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_valid
);

    logic [TAG_W-1:0] r_tag0;
    logic [TAG_W-1:0] r_tag1;
    logic             r_valid0;
    logic             r_valid1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag0   <= '0;
            r_tag1   <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else if (i_clear) begin
            r_tag0   <= '0;
            r_tag1   <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else if (i_push) begin
            r_tag1   <= r_tag0;
            r_valid1 <= r_valid0;
            r_tag0   <= i_tag;
            r_valid0 <= i_valid;
        end
    end

    assign o_tag   = r_tag1;
    assign o_valid = r_valid1;

endmodule

`default_nettype wire

// File: rtl/rhd_convert_sequencer.sv
// ============================================================================
// Module  : rhd_convert_sequencer
// Brief   : Issues RHD2164 CONVERT frames over SPI and tags returned results.
//           Optional frame counter enabled by RHD_SEQ_FRAME_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rhd_convert_sequencer
    import rhd_convert_sequencer_pkg::*;
#(
    parameter int NUM_CMD   = 32,
    parameter int FLUSH_CMD = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    input  logic        i_fast_settle,
    output logic        o_spi_start,
    output logic [15:0] o_spi_din,
    input  logic        i_spi_done,
    input  logic [31:0] i_spi_dout,
    output logic        o_sample_valid,
    output logic [31:0] o_sample_data,
    output logic [5:0]  o_sample_cmd,
    output logic        o_frame_last,
    output logic        o_busy
`ifdef RHD_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam logic [5:0] c_LAST_IDX   = 6'(NUM_CMD - 1);
    localparam logic [5:0] c_LAST_FLUSH = 6'(FLUSH_CMD - 1);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    logic [5:0]  r_idx;
    logic [5:0]  r_flush_cnt;
    logic        r_h;
    logic        r_sample_valid;
    logic [31:0] r_sample_data;
    logic [5:0]  r_sample_cmd;
    logic        r_frame_last;

    logic        w_in_wait;
    logic        w_push;
    logic        w_clear;
    logic        w_emit;
    logic [5:0]  w_pipe_tag;
    logic        w_pipe_valid;

    assign w_in_wait = (r_state == ST_WAIT) || (r_state == ST_FLUSH_WAIT);
    assign w_push    = i_spi_done && w_in_wait;
    assign w_clear   = (r_state == ST_IDLE) && i_enable;
    assign w_emit    = w_push && w_pipe_valid;

    // Flush commands carry an invalid tag so they drain results without emitting their own.
    rhd_tag_pipe #(.TAG_W(6)) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_tag   (r_idx),
        .i_valid (r_state == ST_WAIT),
        .o_tag   (w_pipe_tag),
        .o_valid (w_pipe_valid)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:        if (i_enable) w_next_state = ST_ISSUE;
            ST_ISSUE:       w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (i_spi_done) begin
                    if ((r_idx != c_LAST_IDX) || i_enable) w_next_state = ST_ISSUE;
                    else if (FLUSH_CMD == 0)               w_next_state = ST_IDLE;
                    else                                   w_next_state = ST_FLUSH_ISSUE;
                end
            end
            ST_FLUSH_ISSUE: w_next_state = ST_FLUSH_WAIT;
            ST_FLUSH_WAIT: begin
                if (i_spi_done) begin
                    w_next_state = (r_flush_cnt == c_LAST_FLUSH) ? ST_IDLE : ST_FLUSH_ISSUE;
                end
            end
            default:        w_next_state = ST_IDLE;
        endcase
    end

    // Fast-settle is latched at every frame start, including back-to-back wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx       <= '0;
            r_flush_cnt <= '0;
            r_h         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_idx <= '0;
                        r_h   <= i_fast_settle;
                    end
                end
                ST_WAIT: begin
                    if (i_spi_done) begin
                        if (r_idx != c_LAST_IDX) begin
                            r_idx <= r_idx + 6'd1;
                        end else if (i_enable) begin
                            r_idx <= '0;
                            r_h   <= i_fast_settle;
                        end else begin
                            r_flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH_WAIT: begin
                    if (i_spi_done) r_flush_cnt <= r_flush_cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_sample_cmd   <= '0;
            r_frame_last   <= 1'b0;
        end else begin
            r_sample_valid <= w_emit;
            r_frame_last   <= w_emit && (w_pipe_tag == c_LAST_IDX);
            if (w_emit) begin
                r_sample_data <= i_spi_dout;
                r_sample_cmd  <= w_pipe_tag;
            end
        end
    end

`ifdef RHD_SEQ_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_emit && (w_pipe_tag == c_LAST_IDX)) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

    assign o_spi_start    = (r_state == ST_ISSUE) || (r_state == ST_FLUSH_ISSUE);
    assign o_spi_din      = build_convert_cmd(
                                ((r_state == ST_FLUSH_ISSUE) || (r_state == ST_FLUSH_WAIT)) ? r_flush_cnt : r_idx,
                                r_h);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_sample_valid = r_sample_valid;
    assign o_sample_data  = r_sample_data;
    assign o_sample_cmd   = r_sample_cmd;
    assign o_frame_last   = r_frame_last;

endmodule

`default_nettype wire

// File: tb/tb_rhd_convert_sequencer.sv
// ============================================================================
// Module  : tb_rhd_convert_sequencer
// Brief   : Self-checking bench: cycle vector table, reset corner case and a
//           randomized SPI responder against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rhd_convert_sequencer;

    localparam int NUM_CMD   = 4;
    localparam int FLUSH_CMD = 2;
    localparam int RAND_CYC  = 3000;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_fast_settle = 1'b0;
    logic        i_spi_done = 1'b0;
    logic [31:0] i_spi_dout = '0;
    logic        o_spi_start;
    logic [15:0] o_spi_din;
    logic        o_sample_valid;
    logic [31:0] o_sample_data;
    logic [5:0]  o_sample_cmd;
    logic        o_frame_last;
    logic        o_busy;
`ifdef RHD_SEQ_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    rhd_convert_sequencer #(.NUM_CMD(NUM_CMD), .FLUSH_CMD(FLUSH_CMD)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_fast_settle  (i_fast_settle),
        .o_spi_start    (o_spi_start),
        .o_spi_din      (o_spi_din),
        .i_spi_done     (i_spi_done),
        .i_spi_dout     (i_spi_dout),
        .o_sample_valid (o_sample_valid),
        .o_sample_data  (o_sample_data),
        .o_sample_cmd   (o_sample_cmd),
        .o_frame_last   (o_frame_last),
        .o_busy         (o_busy)
`ifdef RHD_SEQ_FRAME_CNT_EN
        ,
        .o_frame_cnt    (o_frame_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        en;
        logic        fs;
        logic        done;
        logic [31:0] dout;
        logic        start;
        logic        busy;
        logic [15:0] din;
        logic        sv;
        logic [5:0]  cmd;
        logic [31:0] data;
        logic        last;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic fs, input logic done, input logic [31:0] dout,
                                input logic start, input logic busy, input logic [15:0] din,
                                input logic sv, input logic [5:0] cmd, input logic [31:0] data, input logic last);
        vec_t v;
        v = '{en, fs, done, dout, start, busy, din, sv, cmd, data, last};
        return v;
    endfunction

    typedef struct {
        bit real_cmd;
        int idx;
    } trans_t;

    vec_t   vecs[15];
    trans_t tq[$];

    initial begin
        bit          run_active = 0;
        bit          outstanding = 0;
        bit          flushing = 0;
        bit          run_h = 0;
        bit          nxt_sv = 0;
        int          pos = 0;
        int          fk = 0;
        int          lat = 0;
        int          gap = 0;
        int          nxt_cmd = 0;
        int          m_frames = 0;
        int          cur_idx;
        logic [31:0] nxt_data = '0;
        logic [15:0] cur_word = '0;
        logic [15:0] exp_word;
        trans_t      t;

        // en, fs, done, dout | start, busy, din, sv, cmd, data, last
        vecs[0]  = mk(0, 0, 1, 32'hDEAD_0000, 0, 0, 16'h0000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 32'h0,         1, 1, 16'h0001, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 32'hBEEF_0000, 0, 1, 16'h0001, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 1, 32'hA001_B001, 1, 1, 16'h0101, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 0, 32'h0,         0, 1, 16'h0101, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 1, 32'hA002_B002, 1, 1, 16'h0201, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 0, 32'h0,         0, 1, 16'h0201, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 1, 32'hA003_B003, 1, 1, 16'h0301, 1, 0, 32'hA003_B003, 0);
        vecs[8]  = mk(0, 1, 0, 32'h0,         0, 1, 16'h0301, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 1, 32'hA004_B004, 1, 1, 16'h0001, 1, 1, 32'hA004_B004, 0);
        vecs[10] = mk(0, 1, 0, 32'h0,         0, 1, 16'h0001, 0, 0, 0, 0);
        vecs[11] = mk(1, 1, 1, 32'hA005_B005, 1, 1, 16'h0101, 1, 2, 32'hA005_B005, 0);
        vecs[12] = mk(1, 1, 0, 32'h0,         0, 1, 16'h0101, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 32'hA006_B006, 0, 0, 16'h0000, 1, 3, 32'hA006_B006, 1);
        vecs[14] = mk(0, 1, 0, 32'h0,         0, 0, 16'h0000, 0, 0, 0, 0);

        // Reset state
        repeat (3) @(negedge i_clk);
        chk("rst_start", o_spi_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_din", o_spi_din, 0);
        chk("rst_sv", o_sample_valid, 0);
        chk("rst_data", o_sample_data, 0);
        chk("rst_cmd", o_sample_cmd, 0);
        chk("rst_last", o_frame_last, 0);
`ifdef RHD_SEQ_FRAME_CNT_EN
        chk("rst_frame_cnt", o_frame_cnt, 0);
`endif
        i_rst_n = 1'b1;

        // Cycle-accurate frame with stray dones, early disable and flush
        for (int i = 0; i < 15; i++) begin
            i_enable      = vecs[i].en;
            i_fast_settle = vecs[i].fs;
            i_spi_done    = vecs[i].done;
            i_spi_dout    = vecs[i].dout;
            @(negedge i_clk);
            chk($sformatf("vec%0d_start", i), o_spi_start, vecs[i].start);
            chk($sformatf("vec%0d_busy", i), o_busy, vecs[i].busy);
            chk($sformatf("vec%0d_sv", i), o_sample_valid, vecs[i].sv);
            chk($sformatf("vec%0d_last", i), o_frame_last, vecs[i].last);
            if (vecs[i].busy) chk($sformatf("vec%0d_din", i), o_spi_din, vecs[i].din);
            if (vecs[i].sv) begin
                chk($sformatf("vec%0d_cmd", i), o_sample_cmd, vecs[i].cmd);
                chk($sformatf("vec%0d_data", i), o_sample_data, vecs[i].data);
            end
        end
        i_spi_done = 1'b0;
`ifdef RHD_SEQ_FRAME_CNT_EN
        chk("vec_frame_cnt", o_frame_cnt, 1);
`endif

        // Reset while waiting on a transaction, then a spurious done
        i_enable      = 1'b1;
        i_fast_settle = 1'b0;
        @(negedge i_clk);
        chk("rstw_start", o_spi_start, 1);
        i_enable = 1'b0;
        @(negedge i_clk);
        chk("rstw_in_wait", o_busy, 1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("rstw_busy_in_rst", o_busy, 0);
        i_rst_n    = 1'b1;
        i_spi_done = 1'b1;
        i_spi_dout = 32'h5555_AAAA;
        @(negedge i_clk);
        i_spi_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstw_sv", o_sample_valid, 0);
            chk("rstw_busy", o_busy, 0);
            chk("rstw_start_idle", o_spi_start, 0);
            @(negedge i_clk);
        end
`ifdef RHD_SEQ_FRAME_CNT_EN
        chk("rstw_frame_cnt", o_frame_cnt, 0);
`endif

        // Randomized run against a transaction-level model
        for (int cyc = 0; cyc < RAND_CYC + 800; cyc++) begin
            @(negedge i_clk);
            chk("rand_sv", o_sample_valid, nxt_sv);
            if (nxt_sv) begin
                chk("rand_cmd", o_sample_cmd, nxt_cmd);
                chk("rand_data", o_sample_data, nxt_data);
                chk("rand_last", o_frame_last, (nxt_cmd == NUM_CMD - 1));
            end else begin
                chk("rand_last_quiet", o_frame_last, 0);
            end
            nxt_sv = 0;

            if (o_spi_start) begin
                if (!run_active) begin
                    chk("rand_start_en", i_enable, 1);
                    run_active = 1;
                    run_h      = i_fast_settle;
                    pos        = 0;
                    flushing   = 0;
                    fk         = 0;
                    tq.delete();
                end
                chk("rand_start_dup", outstanding, 0);
                exp_word = 16'(((flushing ? fk : pos) << 8) | int'(run_h));
                chk("rand_din", o_spi_din, exp_word);
                cur_word    = exp_word;
                outstanding = 1;
                lat         = $urandom_range(1, 4);
                gap         = 0;
            end else if (run_active && !outstanding) begin
                gap++;
                chk("rand_issue_gap", (gap <= 3), 1);
                if (gap > 3) run_active = 0;
            end

            i_spi_done = 1'b0;
            if (cyc < RAND_CYC) begin
                if ($urandom_range(0, 19) == 0) i_enable = ~i_enable;
                if (!run_active && $urandom_range(0, 7) == 0) i_fast_settle = 1'($urandom_range(0, 1));
            end else begin
                i_enable = 1'b0;
            end

            if (outstanding && !o_spi_start) begin
                chk("rand_din_hold", o_spi_din, cur_word);
                lat--;
                if (lat == 0) begin
                    i_spi_done = 1'b1;
                    i_spi_dout = $urandom;
                    cur_idx    = flushing ? fk : pos;
                    if (tq.size() == 2) begin
                        t = tq.pop_front();
                        if (t.real_cmd) begin
                            nxt_sv   = 1;
                            nxt_cmd  = t.idx;
                            nxt_data = i_spi_dout;
                            if (t.idx == NUM_CMD - 1) m_frames++;
                        end
                    end
                    tq.push_back('{!flushing, cur_idx});
                    if (!flushing) begin
                        if (pos == NUM_CMD - 1) begin
                            if (i_enable) pos = 0;
                            else begin
                                flushing = 1;
                                fk       = 0;
                            end
                        end else begin
                            pos++;
                        end
                    end else begin
                        fk++;
                        if (fk == FLUSH_CMD) run_active = 0;
                    end
                    outstanding = 0;
                end
            end else if (!run_active && !o_spi_start && $urandom_range(0, 9) == 0) begin
                i_spi_done = 1'b1;
                i_spi_dout = $urandom;
            end

            if (cyc >= RAND_CYC && !run_active && !outstanding && !nxt_sv) break;
        end
        chk("rand_drained", run_active, 0);
        i_spi_done = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rand_end_busy", o_busy, 0);
        chk("rand_end_sv", o_sample_valid, 0);
        chk("rand_frames_seen", (m_frames >= 3), 1);
`ifdef RHD_SEQ_FRAME_CNT_EN
        chk("rand_frame_cnt", o_frame_cnt, 32'(m_frames) & 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rhd_convert_sequencer.md
RHD_CONVERT_SEQUENCER -- requirements
Module: rhd_convert_sequencer

Interface
REQ-001 SHALL have parameter NUM_CMD, default 32, CONVERT commands per frame (2..64); each command yields two channels, one per MISO DDR half.
REQ-002 SHALL have parameter FLUSH_CMD, default 2, dummy commands issued after the last frame to drain the RHD2164 result pipeline.
REQ-003 i_clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_enable  in  1  level; 1 = run frames continuously, 0 = stop at the next frame boundary.
REQ-006 i_fast_settle  in  1  H bit placed in every CONVERT command; sampled at frame start.
REQ-007 o_spi_start  out  1  one-cycle pulse requesting one SPI transaction.
REQ-008 o_spi_din  out  16  command word; held stable from o_spi_start until i_spi_done.
REQ-009 i_spi_done  in  1  one-cycle pulse marking transaction complete.
REQ-010 i_spi_dout  in  32  {B,A} result word; valid in the i_spi_done cycle.
REQ-011 o_sample_valid  out  1  one-cycle pulse; sample fields valid; no backpressure.
REQ-012 o_sample_data  out  32  registered copy of i_spi_dout for the tagged command.
REQ-013 o_sample_cmd  out  6  command index (0..NUM_CMD-1) the sample belongs to.
REQ-014 o_frame_last  out  1  high with o_sample_valid when o_sample_cmd = NUM_CMD-1.
REQ-015 o_busy  out  1  high in any state other than IDLE.

Function
REQ-016 Command word SHALL be {2'b00, idx[5:0], 7'b0, H}.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, FLUSH_ISSUE, FLUSH_WAIT.
REQ-018 IDLE -> ISSUE when i_enable=1; idx cleared to 0, tag pipe cleared, H latched.
REQ-019 ISSUE SHALL assert o_spi_start for exactly one cycle with o_spi_din, then go to WAIT.
REQ-020 WAIT SHALL ignore everything except i_spi_done; on i_spi_done it SHALL shift idx into a 2-deep tag pipe with valid bits.
REQ-021 On i_spi_done, if the tag 2 transactions old is valid, o_sample_valid SHALL pulse on the next cycle (1-cycle latency) with that tag and i_spi_dout.
REQ-022 After WAIT: idx < NUM_CMD-1 -> idx+1, ISSUE; idx = NUM_CMD-1 and i_enable=1 -> idx wraps to 0, ISSUE (tag pipe continues across frames, no gap); idx = NUM_CMD-1 and i_enable=0 -> FLUSH_ISSUE.
REQ-023 FLUSH_ISSUE/FLUSH_WAIT SHALL issue FLUSH_CMD commands CONVERT(0..FLUSH_CMD-1) whose own tags are marked invalid; pending valid tags SHALL still emit samples; then go to IDLE.
REQ-024 i_enable deassert mid-frame SHALL NOT truncate the frame; reassert during flush SHALL be ignored until IDLE.
REQ-025 i_spi_done outside WAIT/FLUSH_WAIT SHALL be ignored.
REQ-026 First two transactions after leaving IDLE SHALL produce no samples.

Reset
REQ-027 Reset SHALL force IDLE; o_spi_start, o_sample_valid, o_frame_last, o_busy = 0; o_spi_din, o_sample_data = 0; o_sample_cmd = 0; tag valids cleared.
REQ-028 Reset mid-transaction SHALL abandon it; no sample emitted for it after reset release.

Configuration
REQ-029 With RHD_SEQ_FRAME_CNT_EN defined, the block SHALL add output o_frame_cnt (16 bits, reset 0) incrementing, wrapping at 0xFFFF->0, in the cycle o_frame_last is emitted; without it the port and counter SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the CONVERT opcode constant (2'b00) and the command-word build function.
REQ-031 The 2-deep tag pipe SHALL be a sub-module rhd_tag_pipe (push, tag, valid-in; out tag, valid-out).

Verification
REQ-032 NUM_CMD=4, enable then SPI model returning dout=idx-tagged words -> samples cmd 0,1,2,3 carry results of transactions 3..6; o_frame_last only on cmd 3.
REQ-033 i_fast_settle=1 -> every o_spi_din has bit0=1; idx 5 word = 0x0501.
REQ-034 i_enable dropped at idx 1 of NUM_CMD=4 -> commands 2,3 issued, then 2 flush commands 0x0000,0x0100, samples through cmd 3, then IDLE, o_busy=0.
REQ-035 Continuous enable for 3 frames -> no sample gap at wrap; sample cmd sequence 0..3 repeats; with RHD_SEQ_FRAME_CNT_EN o_frame_cnt = 3.
REQ-036 i_rst_n asserted in WAIT, spurious i_spi_done after release -> no o_sample_valid, state IDLE.
REQ-037 Stray i_spi_done in IDLE/ISSUE -> no state change, no sample.
